// File: rtl/fault_service_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fault_service_pkg
//  Description : Shared types and default sizes for the fault service
//                controller and its fault log FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fault_service_pkg;

    localparam int c_DATA_WIDTH_DEF  = 8;
    localparam int c_LOG_DEPTH_DEF   = 4;
    localparam int c_ACK_DELAY_DEF   = 2;
    localparam int c_ACK_TIMEOUT_DEF = 8;
    localparam int c_MAX_RETRY_DEF   = 2;
    localparam int c_COUNT_WIDTH_DEF = 8;
    localparam int c_TS_WIDTH_DEF    = 16;

    // Controller states; the encoding is fixed so status readout stays stable.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE    = 3'd1,
        ST_HOLD       = 3'd2,
        ST_ACK        = 3'd3,
        ST_WAIT_CLEAR = 3'd4,
        ST_STUCK      = 3'd5
    } fsm_state_e;

    // Layout of one log entry: timestamp in the upper bits, value below.
    // The FIFO stores entries flattened in this same order.
    typedef struct packed {
        logic [c_TS_WIDTH_DEF-1:0]   timestamp;
        logic [c_DATA_WIDTH_DEF-1:0] value;
    } log_entry_t;

endpackage
`default_nettype wire

// File: rtl/fault_log_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fault_log_fifo
//  Description : First-word fall-through FIFO for fault log entries. A push
//                while full is dropped unless a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fault_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_wr_en;
    logic               w_rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Head reads as zero when empty so stale entries never leak out.
    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fault_service_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fault_service_controller
//  Description : Services the data monitor's alarm: logs each fault value,
//                acknowledges after a hold-off, retries on timeout, flags a
//                stuck alarm and keeps a saturating fault count.
//                Optional macro FAULT_SERVICE_TIMESTAMP_EN stores a capture
//                timestamp with each log entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fault_service_controller
    import fault_service_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH_DEF,
    parameter int LOG_DEPTH   = c_LOG_DEPTH_DEF,
    parameter int ACK_DELAY   = c_ACK_DELAY_DEF,
    parameter int ACK_TIMEOUT = c_ACK_TIMEOUT_DEF,
    parameter int MAX_RETRY   = c_MAX_RETRY_DEF,
    parameter int COUNT_WIDTH = c_COUNT_WIDTH_DEF,
    parameter int TS_WIDTH    = c_TS_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alarm_input,
    input  logic [DATA_WIDTH-1:0]  fault_value,
    input  logic                   log_read,
    input  logic                   clear_flags,
    output logic                   acknowledgement,
    output logic [DATA_WIDTH-1:0]  log_data,
    output logic [TS_WIDTH-1:0]    log_timestamp,
    output logic                   log_empty,
    output logic                   log_full,
    output logic                   log_overflow,
    output logic                   stuck_alarm,
    output logic [COUNT_WIDTH-1:0] fault_count,
    output logic                   busy
);

    localparam logic [2:0] c_IDLE       = ST_IDLE;
    localparam logic [2:0] c_CAPTURE    = ST_CAPTURE;
    localparam logic [2:0] c_HOLD       = ST_HOLD;
    localparam logic [2:0] c_ACK        = ST_ACK;
    localparam logic [2:0] c_WAIT_CLEAR = ST_WAIT_CLEAR;
    localparam logic [2:0] c_STUCK      = ST_STUCK;

    localparam int c_DLY_W = $clog2(ACK_DELAY) + 1;
    localparam int c_TMR_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int c_RTY_W = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [c_DLY_W-1:0]     c_DELAY_INIT = c_DLY_W'(ACK_DELAY - 1);
    localparam logic [c_TMR_W-1:0]     c_TIMER_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0]     c_RETRY_MAX  = c_RTY_W'(MAX_RETRY);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX  = '1;

`ifdef FAULT_SERVICE_TIMESTAMP_EN
    localparam int c_ENTRY_W = DATA_WIDTH + TS_WIDTH;
`else
    localparam int c_ENTRY_W = DATA_WIDTH;
`endif

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [c_DLY_W-1:0]     r_delay;
    logic [c_TMR_W-1:0]     r_timer;
    logic [c_RTY_W-1:0]     r_retry;
    logic                   r_ack;
    logic                   r_overflow;
    logic                   r_stuck;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_capture;
    logic                   w_full;
    logic [c_ENTRY_W-1:0]   w_push_data;
    logic [c_ENTRY_W-1:0]   w_head;

    assign w_capture = (r_state == c_CAPTURE);

    // Next-state selection; a persistent alarm in WAIT_CLEAR is never re-captured.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:       if (alarm_input) w_next = c_CAPTURE;
            c_CAPTURE:    w_next = c_HOLD;
            c_HOLD:       if (r_delay == '0) w_next = c_ACK;
            c_ACK:        w_next = c_WAIT_CLEAR;
            c_WAIT_CLEAR: begin
                if (!alarm_input)
                    w_next = c_IDLE;
                else if (r_timer == c_TIMER_LAST)
                    w_next = (r_retry < c_RETRY_MAX) ? c_ACK : c_STUCK;
            end
            c_STUCK:      if (!alarm_input) w_next = c_IDLE;
            default:      w_next = c_IDLE;
        endcase
    end

    // State register with hold-off, timeout and retry counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_delay <= '0;
            r_timer <= '0;
            r_retry <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == c_ACK);
            case (r_state)
                c_CAPTURE: begin
                    r_delay <= c_DELAY_INIT;
                    r_retry <= '0;
                end
                c_HOLD:    if (r_delay != '0) r_delay <= r_delay - c_DLY_W'(1);
                c_ACK:     r_timer <= '0;
                c_WAIT_CLEAR: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                    if (w_next == c_ACK) r_retry <= r_retry + c_RTY_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Status flags; clear_flags wins over any same-cycle set or increment.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_stuck    <= 1'b0;
            r_count    <= '0;
        end else if (clear_flags) begin
            r_overflow <= 1'b0;
            r_stuck    <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_capture && (r_count != c_COUNT_MAX)) r_count <= r_count + COUNT_WIDTH'(1);
            if (w_capture && w_full && !log_read) r_overflow <= 1'b1;
            if ((r_state == c_WAIT_CLEAR) && (w_next == c_STUCK)) r_stuck <= 1'b1;
        end
    end

`ifdef FAULT_SERVICE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts_count;

    // Free-running timestamp, sampled into the log at capture.
    always_ff @(posedge clock) begin
        if (!reset) r_ts_count <= '0;
        else        r_ts_count <= r_ts_count + TS_WIDTH'(1);
    end

    assign w_push_data   = {r_ts_count, fault_value};
    assign log_data      = w_head[DATA_WIDTH-1:0];
    assign log_timestamp = w_head[c_ENTRY_W-1:DATA_WIDTH];
`else
    assign w_push_data   = fault_value;
    assign log_data      = w_head;
    assign log_timestamp = '0;
`endif

    fault_log_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_capture),
        .i_push_data (w_push_data),
        .i_pop       (log_read),
        .o_head_data (w_head),
        .o_empty     (log_empty),
        .o_full      (w_full)
    );

    assign log_full        = w_full;
    assign acknowledgement = r_ack;
    assign log_overflow    = r_overflow;
    assign stuck_alarm     = r_stuck;
    assign fault_count     = r_count;
    assign busy            = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: doc/fault_service_controller.md
Name: fault_service_controller

Overview:
- Host-side responder to the data monitor's alarm interface.
- Watches the monitor's alarm output and, on each fault, logs the captured fault value into a small FIFO.
- After a programmable hold-off, it pulses the acknowledgement back to the monitor and checks that the alarm clears.
- It retries the acknowledgement on timeout and flags a stuck alarm; it also keeps a saturating fault count for status readout.

Parameters:
DATA_WIDTH, 8, width of fault value / log entry
LOG_DEPTH, 4, FIFO entries; power of 2, >=2
ACK_DELAY, 2, hold-off cycles between capture and acknowledge; >=1
ACK_TIMEOUT, 8, cycles to wait for alarm clear after acknowledge; >=1
MAX_RETRY, 2, re-acknowledge attempts before declaring stuck
COUNT_WIDTH, 8, fault counter width
TS_WIDTH, 16, timestamp width (optional feature only)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
alarm_input  in  1  alarm from monitor (level)
fault_value  in  DATA_WIDTH  monitor's captured fault value
log_read  in  1  pop head of log
clear_flags  in  1  clears overflow, stuck_alarm, fault_count
acknowledgement  out  1  one-cycle acknowledge pulse to monitor
log_data  out  DATA_WIDTH  FIFO head (first-word fall-through)
log_timestamp  out  TS_WIDTH  head timestamp (optional feature)
log_empty  out  1  FIFO empty
log_full  out  1  FIFO full
log_overflow  out  1  sticky: capture attempted while full
stuck_alarm  out  1  sticky: alarm never cleared after retries
fault_count  out  COUNT_WIDTH  saturating count of captures
busy  out  1  state != IDLE

Behaviour:
- Reset (reset low at an edge) puts the block in IDLE.
  - All outputs read 0, except log_empty=1.
  - FIFO pointers and all counters are zeroed.
  - Reset mid-operation abandons the FSM immediately; no pending acknowledge is issued.
- FSM states: IDLE, CAPTURE, HOLD, ACK, WAIT_CLEAR, STUCK.
- IDLE: alarm_input sampled 1 -> CAPTURE.
- CAPTURE (1 cycle):
  - Pushes fault_value sampled this cycle.
  - If full and no simultaneous pop: no write, set log_overflow.
  - fault_count increments, saturating at all-ones.
  - Retry counter cleared; -> HOLD with delay counter = ACK_DELAY-1.
- HOLD: counts down; at 0 -> ACK.
- ACK: acknowledgement=1 for exactly this cycle (registered output); -> WAIT_CLEAR with timer=0.
- Latency: alarm sampled at edge E0 -> acknowledgement high in the cycle after edge E0+ACK_DELAY+1 (3 cycles with defaults).
- WAIT_CLEAR:
  - alarm_input sampled 0 -> IDLE.
  - Otherwise timer++.
  - Timer reaching ACK_TIMEOUT: if retries<MAX_RETRY, retries++ -> ACK; else -> STUCK.
  - No new capture happens in WAIT_CLEAR; a persistent alarm is one fault.
- STUCK: stuck_alarm set (sticky); alarm_input sampled 0 -> IDLE.
- clear_flags:
  - Clears log_overflow, stuck_alarm and fault_count.
  - Takes priority over a same-cycle set or increment; that event is lost.
  - Does not touch FIFO contents or the FSM.
- FIFO:
  - log_data/log_timestamp valid when !log_empty.
  - log_read when empty is ignored.
  - Push+pop same cycle when full: both succeed, occupancy unchanged, no overflow.
  - Push+pop when empty: push only.
  - Pointers wrap modulo LOG_DEPTH; full/empty derived from an extra pointer bit.
- busy=1 in every non-IDLE state.

Optional Feature:
- Macro: FAULT_SERVICE_TIMESTAMP_EN.
- Defined:
  - A free-running TS_WIDTH counter (reset 0, wraps) is sampled in CAPTURE.
  - The sample is stored alongside each log entry and presented on log_timestamp with log_data.
- Undefined: no counter or timestamp storage; log_timestamp tied to 0. The port list is unchanged.

Decomposition:
- Package fault_service_pkg holds:
  - State enum typedef.
  - Default width/depth constants.
  - Log entry struct typedef (value, optional timestamp).
- One sub-module: fault_log_fifo.
  - Parameterized depth/width, first-word fall-through, full/empty outputs.
  - Push-while-full rejected unless a simultaneous pop.

Test Plan:
- Single fault: alarm_input high with fault_value=90; alarm drops 1 cycle after ack.
  - -> ack pulse 3 cycles after alarm sampled.
  - log_data=90, fault_count=1, back to IDLE, busy=0.
- Retry/stuck: alarm held high with value 180.
  - -> ack pulses at the initial point, then at +9 and +18 cycles.
  - Then STUCK, stuck_alarm=1; alarm low -> IDLE.
  - clear_flags -> stuck_alarm=0, fault_count=0.
- Overflow: 5 faults (95,35,60,8,20) with no log_read.
  - -> log_full after 4th; log_overflow=1 on 5th.
  - Pops return 95,35,60,8 in order, then log_empty=1.
- Pop/push collision: FIFO full, log_read asserted in the CAPTURE cycle of value 150.
  - -> no overflow; last pop order ends with 150.
- Reset mid-HOLD: reset low during HOLD.
  - -> no ack ever issued; outputs at reset values; log_empty=1.
- Timestamp (macro defined): faults 10 cycles apart.
  - -> consecutive log_timestamp values differ by 10.
